// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the Nexys Starship fault generator.
// Decodes one LFSR sample into the roll, channel and repair combo fields.
package nexys_starship_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StArm  = 3'b010,
        StRun  = 3'b100
    } gen_state_e;

    typedef enum logic [1:0] {
        ChLl = 2'd0,
        ChRr = 2'd1,
        ChUr = 2'd2,
        ChDr = 2'd3
    } chan_e;

    localparam logic [15:0] LfsrMask = 16'hB400;

    localparam logic [7:0] DefThr0 = 8'd8;
    localparam logic [7:0] DefThr1 = 8'd16;
    localparam logic [7:0] DefThr2 = 8'd32;
    localparam logic [7:0] DefThr3 = 8'd64;

    typedef struct packed {
        logic [7:0] roll;
        logic [1:0] ch;
        logic [3:0] hex;
    } roll_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LfsrMask) : (l >> 1);
    endfunction

    // A zero combo cannot be entered by the player, so it is remapped to 1.
    function automatic roll_t decode_roll(input logic [15:0] l);
        roll_t r;
        r.roll = l[7:0];
        r.ch   = l[9:8];
        r.hex  = (l[15:12] == 4'h0) ? 4'h1 : l[15:12];
        return r;
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Galois LFSR, right-shifting, taps x^16+x^14+x^13+x^11+1.
// Advances on every clock edge; SEED must be non-zero.
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        timer_clk,
    input  logic        Reset,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/nexys_starship_break_gen.sv
// Random fault generator: picks when and which ship part breaks and the combo to fix it.
// Sequences IDLE -> ARM -> RUN with per-channel holdoff and busy gating.
module nexys_starship_break_gen
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter logic [7:0]  WARMUP  = 8'd4,
    parameter logic [7:0]  HOLDOFF = 8'd20,
    parameter logic [7:0]  THR0    = DefThr0,
    parameter logic [7:0]  THR1    = DefThr1,
    parameter logic [7:0]  THR2    = DefThr2,
    parameter logic [7:0]  THR3    = DefThr3
) (
    input  logic       timer_clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic [1:0] difficulty,
    input  logic [3:0] ch_busy,
    output logic [3:0] break_req,
    output logic [3:0] random_hex,
    output logic [7:0] break_count,
    output logic [2:0] gen_state
);

    logic [15:0]     w_lfsr;
    roll_t           w_roll;
    logic [7:0]      w_thr;
    logic            w_fire;

    gen_state_e      r_state;
    logic [7:0]      r_warm;
    logic [3:0][7:0] r_hold;
    logic [3:0]      r_req;
    logic [3:0]      r_hex;
    logic [7:0]      r_cnt;

    nexys_starship_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .timer_clk (timer_clk),
        .Reset     (Reset),
        .o_lfsr    (w_lfsr)
    );

    always_comb begin
        w_roll = decode_roll(w_lfsr);
        unique case (difficulty)
            2'd0:    w_thr = THR0;
            2'd1:    w_thr = THR1;
            2'd2:    w_thr = THR2;
            default: w_thr = THR3;
        endcase
        w_fire = (w_roll.roll < w_thr) && !ch_busy[w_roll.ch] && (r_hold[w_roll.ch] == 8'd0);
    end

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= StIdle;
            r_warm  <= 8'd0;
            r_hold  <= '0;
            r_req   <= 4'd0;
            r_hex   <= 4'h1;
            r_cnt   <= 8'd0;
        end else begin
            r_req <= 4'd0;
            unique case (r_state)
                StIdle: begin
                    r_warm <= 8'd0;
                    r_hold <= '0;
                    r_cnt  <= 8'd0;
                    if (play_flag && !gameover_ctrl) begin
                        r_state <= StArm;
                    end
                end
                StArm: begin
                    if (gameover_ctrl) begin
                        r_state <= StIdle;
                        r_warm  <= 8'd0;
                        r_hold  <= '0;
                        r_cnt   <= 8'd0;
                    end else if (r_warm == WARMUP - 8'd1) begin
                        r_state <= StRun;
                        r_warm  <= 8'd0;
                    end else begin
                        r_warm <= r_warm + 8'd1;
                    end
                end
                StRun: begin
                    // Gameover wins over a fire on the same tick.
                    if (gameover_ctrl) begin
                        r_state <= StIdle;
                        r_warm  <= 8'd0;
                        r_hold  <= '0;
                        r_cnt   <= 8'd0;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (r_hold[i] != 8'd0) begin
                                r_hold[i] <= r_hold[i] - 8'd1;
                            end
                        end
                        if (w_fire) begin
                            r_req            <= 4'(1) << w_roll.ch;
                            r_hex            <= w_roll.hex;
                            r_hold[w_roll.ch] <= HOLDOFF;
                            if (r_cnt != 8'hFF) begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign break_req   = r_req;
    assign random_hex  = r_hex;
    assign break_count = r_cnt;
    assign gen_state   = r_state;

endmodule
